rs485_lane_bank: RTL and testbench
==================================

// Module: rs485_lane_bank
// PURPOSE
//  N_CH half-duplex RS-485 transceiver lanes (R/D/nRE/DE per lane) with per-lane direction FSM.
//  Replaces hard tie-offs of the FH*/FL* transceiver pins at board top level.
//  Adds turnaround guard times, break-before-make switching, a tx grant handshake and synchronised rx.
//  Sits between the HSI master/slave line drivers and the transceiver pins.
// PARAMETERS
//  N_CH        22  number of transceiver lanes
//  GUARD_CYC   8   clk cycles DE is held with D=1 (mark) before the first tx bit and after the last
//  SYNC_STAGES 2   rx synchroniser depth, >=2
// PORTS
//  clk      in   1     system clock (CLK_48 domain)
//  n_rst    in   1     asynchronous reset, active-low
//  ch_en    in   N_CH  lane enable; 0 = lane parked in board-safe tie-off
//  tx_req   in   N_CH  level request to drive the line
//  tx_d     in   N_CH  serial tx bit, forwarded to pin_d while tx_gnt=1
//  tx_gnt   out  N_CH  driver on, guard elapsed; tx_d is now on the line
//  busy     out  N_CH  lane not in IDLE/DISABLED
//  rx_q     out  N_CH  synchronised receive bit; 1 when receiver is off
//  pin_r    in   N_CH  transceiver R outputs (asynchronous)
//  pin_d    out  N_CH  transceiver D
//  pin_nre  out  N_CH  transceiver nRE
//  pin_de   out  N_CH  transceiver DE
//  collision out N_CH  (RS485_ECHO_EN only) sticky echo-mismatch flag
// BEHAVIOUR
//  - All outputs registered. Reset (async, immediate): state DISABLED, pin_d=0, pin_nre=1, pin_de=0,
//    tx_gnt=0, busy=0, rx_q=1, sync flops=1, collision=0.
//  - DISABLED: tie-off (d=0, nre=1, de=0). ch_en=1 -> IDLE.
//  - IDLE: nre=0, de=0, d=1. tx_req=1 -> ARM.
//  - ARM (1 cycle, break-before-make): nre=1, de=0, d=1 -> TURN_ON, or -> TX if GUARD_CYC=0.
//  - TURN_ON: de=1, d=1 for GUARD_CYC cycles, guard counter width $clog2(GUARD_CYC+1) -> TX.
//  - TX: de=1, tx_gnt=1, pin_d=tx_d delayed one cycle. tx_req=0 -> TURN_OFF, or -> RELEASE if GUARD_CYC=0.
//  - TURN_OFF: de=1, d=1 for GUARD_CYC cycles -> RELEASE.
//  - RELEASE (1 cycle): de=0, nre=1 -> IDLE. nre falls one cycle after de.
//  - Latency: tx_req sampled high in IDLE at edge k -> tx_gnt high after edge k+GUARD_CYC+2.
//  - tx_req dropped in ARM/TURN_ON: finish TURN_ON, skip TX, continue into TURN_OFF.
//  - tx_req re-raised in TURN_OFF/RELEASE: ignored until IDLE.
//  - ch_en=0 in any state: DISABLED at next edge with tie-off; no guard; tx_gnt drops the same edge.
//  - rx_q = last sync stage when pin_nre=0, else forced 1.
//  - Lanes are independent; no arbitration between lanes.
// CONFIGURATION
//  RS485_ECHO_EN defined:
//   - Receiver stays on while driving: nre=0 in TURN_ON/TX/TURN_OFF; ARM/RELEASE unchanged.
//   - In TX, synced echo is compared with pin_d delayed SYNC_STAGES cycles.
//   - Compare is skipped for the first SYNC_STAGES cycles of TX.
//   - A mismatch sets collision[i]; it clears only on leaving DISABLED or on reset.
//  RS485_ECHO_EN undefined: no collision port or logic; nre=1 whenever de=1.
// STRUCTURE
//  - Package rs485_pkg: lane_state_t enum (DISABLED, IDLE, ARM, TURN_ON, TX, TURN_OFF, RELEASE);
//    constants TIE_D=0, TIE_NRE=1, TIE_DE=0, MARK=1.
//  - Sub-module rs485_lane: one FSM, guard counter and rx synchroniser.
//  - Top instantiates rs485_lane N_CH times with a generate loop.
// TESTING
//  - Reset: n_rst low mid-TX -> pins 0/1/0, tx_gnt=0 asynchronously. After release, ch_en=0 -> tie-off holds.
//  - Handshake, GUARD_CYC=8: ch_en=1, tx_req rises -> nre=1 one cycle before de=1.
//    tx_gnt at edge +10; pattern 1011 on tx_d appears on pin_d one cycle later.
//    tx_req falls -> de held 8 cycles, de falls, nre falls one cycle later.
//  - GUARD_CYC=0: tx_req pulse -> ARM, TX, RELEASE, IDLE; tx_gnt high from edge +2; no TURN_ON/TURN_OFF.
//  - Abort: ch_en=0 during TURN_ON, and separately during TX -> next edge tie-off, busy=0, tx_gnt=0.
//  - Rx: lane 3 IDLE, pin_r toggles -> rx_q follows after SYNC_STAGES cycles; while driving rx_q=1 (no ECHO).
//  - ECHO_EN: pin_r forced 0 during TX with tx_d=1 -> collision[i]=1 and sticky.
//    Drop ch_en then re-enable -> collision clears. Other lanes unaffected.

Source files
------------

// File: rtl/rs485_pkg.sv
// Shared types and pin constants for the RS-485 lane bank.
package rs485_pkg;

  typedef enum logic [2:0] {
    DISABLED,
    IDLE,
    ARM,
    TURN_ON,
    TX,
    TURN_OFF,
    RELEASE
  } lane_state_t;

  // Board-safe tie-off levels and the idle-line (mark) level.
  localparam logic TIE_D   = 1'b0;
  localparam logic TIE_NRE = 1'b1;
  localparam logic TIE_DE  = 1'b0;
  localparam logic MARK    = 1'b1;

endpackage

// File: rtl/rs485_lane.sv
// One half-duplex RS-485 lane: direction FSM, guard timer and rx synchroniser.
// Optional feature: RS485_ECHO_EN keeps the receiver on while driving and flags echo mismatches.
module rs485_lane
  import rs485_pkg::*;
#(
  parameter int GUARD_CYC   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic ch_en,
  input  logic tx_req,
  input  logic tx_d,
  input  logic pin_r,
  output logic tx_gnt,
  output logic busy,
  output logic rx_q,
  output logic pin_d,
  output logic pin_nre,
  output logic pin_de
`ifdef RS485_ECHO_EN
  ,
  output logic collision
`endif
);

  localparam int CNT_W = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;

`ifdef RS485_ECHO_EN
  localparam logic DRV_NRE = 1'b0;
`else
  localparam logic DRV_NRE = 1'b1;
`endif

  lane_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             guard_done;
  logic             drop_q;
  logic             d_nx, nre_nx, de_nx, gnt_nx, busy_nx;
  logic [SYNC_STAGES-2:0] sync_p;

  assign guard_done = (cnt == CNT_W'(GUARD_CYC - 1));

  always_comb begin
    state_nx = state;
    if (!ch_en) begin
      state_nx = DISABLED;
    end else begin
      case (state)
        DISABLED: state_nx = IDLE;
        IDLE:     if (tx_req) state_nx = ARM;
        ARM: begin
          if (GUARD_CYC == 0) state_nx = tx_req ? TX : RELEASE;
          else                state_nx = TURN_ON;
        end
        // A request withdrawn during arming still completes the turn-on guard.
        TURN_ON:  if (guard_done) state_nx = (tx_req && !drop_q) ? TX : TURN_OFF;
        TX:       if (!tx_req) state_nx = (GUARD_CYC == 0) ? RELEASE : TURN_OFF;
        TURN_OFF: if (guard_done) state_nx = RELEASE;
        RELEASE:  state_nx = IDLE;
        default:  state_nx = DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= DISABLED;
      cnt    <= '0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= (state_nx != state) ? '0 : cnt + CNT_W'(1);
      drop_q <= ((state == ARM) || (state == TURN_ON)) && (drop_q || !tx_req);
    end
  end

  // Pin levels follow the current state one edge later; ch_en=0 overrides immediately.
  always_comb begin
    d_nx    = TIE_D;
    nre_nx  = TIE_NRE;
    de_nx   = TIE_DE;
    gnt_nx  = 1'b0;
    busy_nx = 1'b0;
    if (ch_en) begin
      case (state)
        IDLE: begin
          nre_nx = 1'b0;
          d_nx   = MARK;
        end
        ARM, RELEASE: begin
          nre_nx  = 1'b1;
          d_nx    = MARK;
          busy_nx = 1'b1;
        end
        TURN_ON, TURN_OFF: begin
          nre_nx  = DRV_NRE;
          de_nx   = 1'b1;
          d_nx    = MARK;
          busy_nx = 1'b1;
        end
        TX: begin
          nre_nx  = DRV_NRE;
          de_nx   = 1'b1;
          gnt_nx  = 1'b1;
          d_nx    = tx_gnt ? tx_d : MARK;
          busy_nx = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pin_d   <= TIE_D;
      pin_nre <= TIE_NRE;
      pin_de  <= TIE_DE;
      tx_gnt  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      pin_d   <= d_nx;
      pin_nre <= nre_nx;
      pin_de  <= de_nx;
      tx_gnt  <= gnt_nx;
      busy    <= busy_nx;
    end
  end

  // rx_q is the final synchroniser stage, forced to idle while the receiver is off.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_p <= '1;
      rx_q   <= 1'b1;
    end else begin
      sync_p[0] <= pin_r;
      for (int i = 1; i < SYNC_STAGES - 1; i++) sync_p[i] <= sync_p[i-1];
      rx_q <= nre_nx ? 1'b1 : sync_p[SYNC_STAGES-2];
    end
  end

`ifdef RS485_ECHO_EN
  localparam int AGE_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] d_dly_p;
  logic [AGE_W-1:0]       age;

  // pin_d is delayed to line up with its echo through the synchroniser.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      d_dly_p   <= '1;
      age       <= '0;
      collision <= 1'b0;
    end else begin
      d_dly_p[0] <= pin_d;
      for (int i = 1; i < SYNC_STAGES; i++) d_dly_p[i] <= d_dly_p[i-1];
      if (!tx_gnt)                          age <= '0;
      else if (age != AGE_W'(SYNC_STAGES))  age <= age + AGE_W'(1);
      if ((state == DISABLED) && ch_en)
        collision <= 1'b0;
      else if (tx_gnt && (age == AGE_W'(SYNC_STAGES)) && (rx_q != d_dly_p[SYNC_STAGES-1]))
        collision <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/rs485_lane_bank.sv
// Bank of N_CH independent RS-485 transceiver lanes between the HSI line drivers and the pins.
// Optional feature: RS485_ECHO_EN adds per-lane sticky echo-collision flags.
module rs485_lane_bank
  import rs485_pkg::*;
#(
  parameter int N_CH        = 22,
  parameter int GUARD_CYC   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [N_CH-1:0] ch_en,
  input  logic [N_CH-1:0] tx_req,
  input  logic [N_CH-1:0] tx_d,
  output logic [N_CH-1:0] tx_gnt,
  output logic [N_CH-1:0] busy,
  output logic [N_CH-1:0] rx_q,
  input  logic [N_CH-1:0] pin_r,
  output logic [N_CH-1:0] pin_d,
  output logic [N_CH-1:0] pin_nre,
  output logic [N_CH-1:0] pin_de
`ifdef RS485_ECHO_EN
  ,
  output logic [N_CH-1:0] collision
`endif
);

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    rs485_lane #(
      .GUARD_CYC   (GUARD_CYC),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_lane (
      .clk       (clk),
      .n_rst     (n_rst),
      .ch_en     (ch_en[i]),
      .tx_req    (tx_req[i]),
      .tx_d      (tx_d[i]),
      .pin_r     (pin_r[i]),
      .tx_gnt    (tx_gnt[i]),
      .busy      (busy[i]),
      .rx_q      (rx_q[i]),
      .pin_d     (pin_d[i]),
      .pin_nre   (pin_nre[i]),
      .pin_de    (pin_de[i])
`ifdef RS485_ECHO_EN
      ,
      .collision (collision[i])
`endif
    );
  end

endmodule

// File: tb/tb_rs485_lane_bank.sv
// Scoreboard bench for rs485_lane_bank: GUARD_CYC=8 bank plus a GUARD_CYC=0 bank.
module tb_rs485_lane_bank;

  localparam int N  = 22;
  localparam int N0 = 2;

  logic         clk;
  logic         n_rst;
  logic [N-1:0] ch_en, tx_req, tx_d, pin_r_drv, loop_mask, jam_mask;
  logic [N-1:0] pin_r;
  logic [N-1:0] tx_gnt, busy, rx_q, pin_d, pin_nre, pin_de;
`ifdef RS485_ECHO_EN
  logic [N-1:0] collision;
  logic [N0-1:0] d0_collision;
`endif

  logic [N0-1:0] d0_ch_en, d0_tx_req, d0_tx_d, d0_pin_r;
  logic [N0-1:0] d0_tx_gnt, d0_busy, d0_rx_q, d0_pin_d, d0_pin_nre, d0_pin_de;

  int   tests_run = 0;
  int   fails     = 0;
  logic exp_q[$];

  assign pin_r = (pin_r_drv & ~loop_mask) | (pin_d & loop_mask & ~jam_mask);

  rs485_lane_bank #(.N_CH(N), .GUARD_CYC(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .n_rst(n_rst), .ch_en(ch_en), .tx_req(tx_req), .tx_d(tx_d),
    .tx_gnt(tx_gnt), .busy(busy), .rx_q(rx_q), .pin_r(pin_r),
    .pin_d(pin_d), .pin_nre(pin_nre), .pin_de(pin_de)
`ifdef RS485_ECHO_EN
    , .collision(collision)
`endif
  );

  rs485_lane_bank #(.N_CH(N0), .GUARD_CYC(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .n_rst(n_rst), .ch_en(d0_ch_en), .tx_req(d0_tx_req), .tx_d(d0_tx_d),
    .tx_gnt(d0_tx_gnt), .busy(d0_busy), .rx_q(d0_rx_q), .pin_r(d0_pin_r),
    .pin_d(d0_pin_d), .pin_nre(d0_pin_nre), .pin_de(d0_pin_de)
`ifdef RS485_ECHO_EN
    , .collision(d0_collision)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_gnt(input int lane, input string tag);
    int n = 0;
    while (tx_gnt[lane] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests_run++;
    if (tx_gnt[lane] !== 1'b1) begin
      fails++;
      $display("FAIL %s_gnt_timeout: tx_gnt=%b want 1", tag, tx_gnt[lane]);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick(3);
    tests_run++;
    if ({pin_d, pin_nre, pin_de, tx_gnt, busy, rx_q} !== {{N{1'b0}}, {N{1'b1}}, {N{1'b0}}, {N{1'b0}}, {N{1'b0}}, {N{1'b1}}}) begin
      fails++;
      $display("FAIL reset_state: d=%h nre=%h de=%h gnt=%h busy=%h rx=%h want 0/3fffff/0/0/0/3fffff",
               pin_d, pin_nre, pin_de, tx_gnt, busy, rx_q);
    end
    n_rst = 1'b1;
    tick(4);
    tests_run++;
    if ({pin_d, pin_nre, pin_de, busy} !== {{N{1'b0}}, {N{1'b1}}, {N{1'b0}}, {N{1'b0}}}) begin
      fails++;
      $display("FAIL tieoff_hold: d=%h nre=%h de=%h busy=%h want 0/3fffff/0/0", pin_d, pin_nre, pin_de, busy);
    end
  endtask

  task automatic test_handshake();
    logic [3:0] pat = 4'b1011;
    logic       got, exp;
    ch_en[0] = 1'b1;
    tick(3);
    tests_run++;
    if ({pin_nre[0], pin_de[0], pin_d[0]} !== 3'b001) begin
      fails++;
      $display("FAIL hs_idle: nre/de/d=%b want 001", {pin_nre[0], pin_de[0], pin_d[0]});
    end
    tx_req[0] = 1'b1;
    tick(2);  // edge k+1: ARM visible
    tests_run++;
    if ({pin_nre[0], pin_de[0], busy[0]} !== 3'b101) begin
      fails++;
      $display("FAIL hs_bbm_arm: nre/de/busy=%b want 101", {pin_nre[0], pin_de[0], busy[0]});
    end
    tick();   // edge k+2
    tests_run++;
    if ({pin_nre[0], pin_de[0], pin_d[0]} !== 3'b111) begin
      fails++;
      $display("FAIL hs_de_on: nre/de/d=%b want 111", {pin_nre[0], pin_de[0], pin_d[0]});
    end
    tick(7);  // edge k+9
    tests_run++;
    if (tx_gnt[0] !== 1'b0) begin
      fails++;
      $display("FAIL hs_gnt_early: tx_gnt=%b want 0", tx_gnt[0]);
    end
    tick();   // edge k+10
    tests_run++;
    if ({tx_gnt[0], pin_d[0]} !== 2'b11) begin
      fails++;
      $display("FAIL hs_gnt_on: gnt/d=%b want 11", {tx_gnt[0], pin_d[0]});
    end
    for (int i = 3; i >= 0; i--) begin
      tx_d[0] = pat[i];
      exp_q.push_back(pat[i]);
      tick();
      got = pin_d[0];
      exp = exp_q.pop_front();
      tests_run++;
      if (got !== exp) begin
        fails++;
        $display("FAIL hs_data_bit%0d: pin_d=%b want %b", i, got, exp);
      end
    end
    tx_d[0]   = 1'b1;
    tx_req[0] = 1'b0;
    tick();   // edge j: still TX
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if ({pin_de[0], tx_gnt[0], pin_d[0], pin_nre[0]} !== 4'b1011) begin
        fails++;
        $display("FAIL hs_turnoff_%0d: de/gnt/d/nre=%b want 1011", i, {pin_de[0], tx_gnt[0], pin_d[0], pin_nre[0]});
      end
    end
    tick();   // edge j+9: RELEASE
    tests_run++;
    if ({pin_de[0], pin_nre[0]} !== 2'b01) begin
      fails++;
      $display("FAIL hs_release: de/nre=%b want 01", {pin_de[0], pin_nre[0]});
    end
    tick();
    tests_run++;
    if ({pin_nre[0], busy[0]} !== 2'b00) begin
      fails++;
      $display("FAIL hs_back_idle: nre/busy=%b want 00", {pin_nre[0], busy[0]});
    end
  endtask

  task automatic test_guard0();
    d0_ch_en[0] = 1'b1;
    tick(3);
    d0_tx_req[0] = 1'b1;
    tick(2);  // edge k+1: ARM visible
    tests_run++;
    if ({d0_pin_nre[0], d0_pin_de[0], d0_tx_gnt[0]} !== 3'b100) begin
      fails++;
      $display("FAIL g0_arm: nre/de/gnt=%b want 100", {d0_pin_nre[0], d0_pin_de[0], d0_tx_gnt[0]});
    end
    d0_tx_req[0] = 1'b0;
    tick();   // edge k+2
    tests_run++;
    if ({d0_pin_de[0], d0_tx_gnt[0]} !== 2'b11) begin
      fails++;
      $display("FAIL g0_gnt: de/gnt=%b want 11", {d0_pin_de[0], d0_tx_gnt[0]});
    end
    tick();
    tests_run++;
    if ({d0_pin_de[0], d0_pin_nre[0], d0_tx_gnt[0]} !== 3'b010) begin
      fails++;
      $display("FAIL g0_release: de/nre/gnt=%b want 010", {d0_pin_de[0], d0_pin_nre[0], d0_tx_gnt[0]});
    end
    tick();
    tests_run++;
    if ({d0_pin_nre[0], d0_busy[0]} !== 2'b00) begin
      fails++;
      $display("FAIL g0_idle: nre/busy=%b want 00", {d0_pin_nre[0], d0_busy[0]});
    end
  endtask

  task automatic test_abort();
    ch_en[1] = 1'b1;
    tick(3);
    tx_req[1] = 1'b1;
    tick(4);
    ch_en[1] = 1'b0;
    tick();
    tests_run++;
    if ({pin_d[1], pin_nre[1], pin_de[1], busy[1], tx_gnt[1]} !== 5'b01000) begin
      fails++;
      $display("FAIL abort_turnon: d/nre/de/busy/gnt=%b want 01000", {pin_d[1], pin_nre[1], pin_de[1], busy[1], tx_gnt[1]});
    end
    ch_en[1] = 1'b1;
    wait_gnt(1, "abort");
    ch_en[1] = 1'b0;
    tick();
    tests_run++;
    if ({pin_d[1], pin_nre[1], pin_de[1], busy[1], tx_gnt[1]} !== 5'b01000) begin
      fails++;
      $display("FAIL abort_tx: d/nre/de/busy/gnt=%b want 01000", {pin_d[1], pin_nre[1], pin_de[1], busy[1], tx_gnt[1]});
    end
    tx_req[1] = 1'b0;
  endtask

  task automatic test_rx();
    logic [4:0] pat = 5'b01101;
    logic       prev = 1'b1;
    logic       exp;
    int         n = 0;
    ch_en[3] = 1'b1;
    tick(3);
    for (int i = 4; i >= 0; i--) begin
      pin_r_drv[3] = pat[i];
      exp_q.push_back(pat[i]);
      tick();
      tests_run++;
      if (rx_q[3] !== prev) begin
        fails++;
        $display("FAIL rx_latency_%0d: rx_q=%b want %b", i, rx_q[3], prev);
      end
      tick();
      exp = exp_q.pop_front();
      tests_run++;
      if (rx_q[3] !== exp) begin
        fails++;
        $display("FAIL rx_follow_%0d: rx_q=%b want %b", i, rx_q[3], exp);
      end
      prev = exp;
    end
`ifndef RS485_ECHO_EN
    tx_req[3]    = 1'b1;
    pin_r_drv[3] = 1'b0;
    tick(4);
    tests_run++;
    if (rx_q[3] !== 1'b1) begin
      fails++;
      $display("FAIL rx_off_driving: rx_q=%b want 1", rx_q[3]);
    end
`endif
    tx_req[3]    = 1'b0;
    pin_r_drv[3] = 1'b1;
    while (busy[3] !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    tests_run++;
    if (busy[3] !== 1'b0) begin
      fails++;
      $display("FAIL rx_idle_timeout: busy=%b want 0", busy[3]);
    end
  endtask

`ifdef RS485_ECHO_EN
  task automatic test_echo();
    loop_mask[6:5] = 2'b11;
    ch_en[6:5]     = 2'b11;
    tick(3);
    tx_req[6:5] = 2'b11;
    wait_gnt(5, "echo");
    tick(6);
    tests_run++;
    if (collision[6:5] !== 2'b00) begin
      fails++;
      $display("FAIL echo_clean: collision=%b want 00", collision[6:5]);
    end
    jam_mask[5] = 1'b1;
    tick(5);
    tests_run++;
    if (collision[5] !== 1'b1) begin
      fails++;
      $display("FAIL echo_detect: collision=%b want 1", collision[5]);
    end
    jam_mask[5] = 1'b0;
    tick(3);
    tests_run++;
    if (collision[6:5] !== 2'b01) begin
      fails++;
      $display("FAIL echo_sticky: collision[6:5]=%b want 01", collision[6:5]);
    end
    tx_req[6:5] = 2'b00;
    ch_en[5]    = 1'b0;
    tick();
    ch_en[5] = 1'b1;
    tick(2);
    tests_run++;
    if (collision[5] !== 1'b0) begin
      fails++;
      $display("FAIL echo_clear: collision=%b want 0", collision[5]);
    end
    ch_en[6:5]     = 2'b00;
    loop_mask[6:5] = 2'b00;
  endtask
`endif

  task automatic test_async_reset();
    ch_en[2] = 1'b1;
    tick(3);
    tx_req[2] = 1'b1;
    wait_gnt(2, "arst");
    #2;
    n_rst = 1'b0;
    #1;
    tests_run++;
    if ({pin_d[2], pin_nre[2], pin_de[2], tx_gnt[2]} !== 4'b0100 || pin_de !== '0 || rx_q !== '1) begin
      fails++;
      $display("FAIL arst_immediate: d/nre/de/gnt=%b de=%h rx=%h want 0100/0/3fffff",
               {pin_d[2], pin_nre[2], pin_de[2], tx_gnt[2]}, pin_de, rx_q);
    end
    ch_en  = '0;
    tx_req = '0;
    tick();
    n_rst = 1'b1;
    tick(4);
    tests_run++;
    if ({pin_d, pin_nre, pin_de, busy} !== {{N{1'b0}}, {N{1'b1}}, {N{1'b0}}, {N{1'b0}}}) begin
      fails++;
      $display("FAIL arst_tieoff: d=%h nre=%h de=%h busy=%h want 0/3fffff/0/0", pin_d, pin_nre, pin_de, busy);
    end
  endtask

  initial begin
    n_rst     = 1'b0;
    ch_en     = '0;
    tx_req    = '0;
    tx_d      = '1;
    pin_r_drv = '1;
    loop_mask = '0;
    jam_mask  = '0;
    d0_ch_en  = '0;
    d0_tx_req = '0;
    d0_tx_d   = '1;
    d0_pin_r  = '1;
    test_reset();
    test_handshake();
    test_guard0();
    test_abort();
    test_rx();
`ifdef RS485_ECHO_EN
    test_echo();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
